// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the latency-programmable data-memory responder
package dmem_pkg;
  localparam int LAT_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef struct packed {
    logic        Write;
    logic [31:0] Adr;
    logic [31:0] WData;
    logic [3:0]  BE;
  } req_t;
endpackage

// File: rtl/bytewe_ram.sv
// bytewe_ram: word RAM with synchronous byte-lane write and a registered read port that doubles as the response data
module bytewe_ram #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     acc,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wdata,
  input  logic [3:0]               be,
  output logic [31:0]              rdata
);
  logic [31:0] mem [DEPTH];
  for (genvar b = 0; b < 4; b++) begin : g_lane
    always_ff @(posedge clk)
      if (!reset && acc && we && be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) rdata <= '0;
    else if (acc) rdata <= re ? mem[idx] : '0;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with programmable access latency and byte-lane stores
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAdr,
  input  logic [31:0] ReqWData,
  input  logic [3:0]  ReqBE,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespRData,
  output logic        RespErr
);
  localparam int AW = $clog2(DEPTH);
  state_t state;
  logic [LAT_W-1:0] cnt;
  req_t req, cur;
  logic acc, err;
  assign ReqReady  = state == IDLE;
  assign RespValid = state == RESP;
  // With zero latency the access uses the live request in the same edge it is captured
  always_comb begin
    cur = (state == IDLE) ? '{Write: ReqWrite, Adr: ReqAdr, WData: ReqWData, BE: ReqBE} : req;
    acc = (state == IDLE) ? (ReqValid && LATENCY == 0) : (state == WAIT && cnt == '0);
    err = (|cur.Adr[1:0]) || (cur.Adr[31:2] >= 30'(DEPTH));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      req     <= '0;
      RespErr <= 1'b0;
    end else begin
      if (state == IDLE && ReqValid) begin
        req   <= cur;
        cnt   <= LAT_W'(LATENCY == 0 ? 0 : LATENCY - 1);
        state <= (LATENCY == 0) ? RESP : WAIT;
      end else if (state == WAIT) begin
        cnt   <= (cnt == '0) ? '0 : cnt - 1'b1;
        state <= (cnt == '0) ? RESP : WAIT;
      end else if (state == RESP && RespReady) state <= IDLE;
      if (acc) RespErr <= err;
    end
  bytewe_ram #(.DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .reset(reset),
    .acc  (acc),
    .we   (cur.Write && !err),
    .re   (!cur.Write && !err),
    .idx  (cur.Adr[AW+1:2]),
    .wdata(cur.WData),
    .be   (cur.BE),
    .rdata(RespRData)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: vector table, hand-written corner sequences and a byte-level reference model
module tb_dmem_responder;
  logic clk = 0, reset = 1;
  logic v2 = 0, v0 = 0, wr = 0, rresp = 1;
  logic [31:0] adr = 0, wdata = 0;
  logic [3:0] bemask = 0;
  logic rdy2, rv2, er2, rdy0, rv0, er0;
  logic [31:0] rd2, rd0;
  int ncmp = 0, nfail = 0;
  logic [7:0] mb [256];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .ReqValid(v2), .ReqReady(rdy2), .ReqWrite(wr), .ReqAdr(adr),
    .ReqWData(wdata), .ReqBE(bemask), .RespValid(rv2), .RespReady(rresp), .RespRData(rd2), .RespErr(er2));
  dmem_responder #(.DEPTH(64), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .ReqValid(v0), .ReqReady(rdy0), .ReqWrite(wr), .ReqAdr(adr),
    .ReqWData(wdata), .ReqBE(bemask), .RespValid(rv0), .RespReady(rresp), .RespRData(rd0), .RespErr(er0));

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] erd;
    bit          eerr;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic txn(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output logic er,
                     output int lat, output time tacc);
    int n;
    @(negedge clk);
    wr = w; adr = a; wdata = wd; bemask = be; rresp = 1;
    if (sel) v0 = 1; else v2 = 1;
    n = 0;
    while (!(sel ? rdy0 : rdy2) && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    tacc = $time;
    #1;
    v0 = 0; v2 = 0;
    wr = 1'($urandom); adr = $urandom; wdata = $urandom; bemask = 4'($urandom);
    lat = 0;
    while (!(sel ? rv0 : rv2) && lat < 50) begin @(posedge clk); #1; lat++; end
    rd = sel ? rd0 : rd2;
    er = sel ? er0 : er2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd, a, wd, exp_rd;
    logic [3:0] be;
    logic er;
    bit w, exp_er;
    int lat, n;
    time t, tprev;

    #3;
    chk("rst_ready", 32'(rdy2), 1);
    chk("rst_valid", 32'(rv2), 0);
    chk("rst_rdata", rd2, 0);
    chk("rst_err", 32'(er2), 0);
    repeat (2) @(negedge clk);
    reset = 0;

    tbl.push_back('{1, 84, 71, 4'hF, 0, 0});
    tbl.push_back('{0, 84, 0, 4'h0, 71, 0});
    tbl.push_back('{1, 0, 32'h11223344, 4'hF, 0, 0});
    tbl.push_back('{1, 0, 32'h000000AA, 4'b0001, 0, 0});
    tbl.push_back('{0, 0, 0, 4'hF, 32'h112233AA, 0});
    tbl.push_back('{1, 0, 32'hDEADBEEF, 4'h0, 0, 0});
    tbl.push_back('{0, 0, 0, 4'h0, 32'h112233AA, 0});
    tbl.push_back('{0, 2, 0, 4'hF, 0, 1});
    tbl.push_back('{1, 256, 32'hFFFFFFFF, 4'hF, 0, 1});
    tbl.push_back('{0, 0, 0, 4'h0, 32'h112233AA, 0});
    tbl.push_back('{0, 84, 0, 4'h0, 71, 0});
    tbl.push_back('{1, 252, 32'hCAFEF00D, 4'hF, 0, 0});
    tbl.push_back('{0, 252, 0, 4'h0, 32'hCAFEF00D, 0});
    tbl.push_back('{0, 256, 0, 4'h0, 0, 1});
    tbl.push_back('{1, 8, 5, 4'hF, 0, 0});
    tbl.push_back('{0, 8, 0, 4'h0, 5, 0});
    foreach (tbl[i]) begin
      txn(0, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].be, rd, er, lat, t);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].erd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].eerr));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 2);
      if (i > 0) chk($sformatf("vec%0d_gap", i), 32'(t - tprev), 40);
      tprev = t;
    end

    // reset while a store sits in WAIT: store must not land, outputs clear asynchronously
    @(negedge clk);
    wr = 1; adr = 8; wdata = 32'hDEADBEEF; bemask = 4'hF; v2 = 1;
    @(posedge clk);
    #1 v2 = 0;
    chk("wait_ready", 32'(rdy2), 0);
    chk("wait_rdata_pre", rd2, 5);
    #2 reset = 1;
    #1;
    chk("arst_ready", 32'(rdy2), 1);
    chk("arst_valid", 32'(rv2), 0);
    chk("arst_rdata", rd2, 0);
    chk("arst_err", 32'(er2), 0);
    @(negedge clk);
    reset = 0;
    txn(0, 0, 8, 0, 4'h0, rd, er, lat, t);
    chk("post_rst_load", rd, 5);
    chk("post_rst_err", 32'(er), 0);

    // backpressure: response held for five cycles
    @(negedge clk);
    wr = 0; adr = 0; bemask = 4'h0; v2 = 1; rresp = 0;
    @(posedge clk);
    #1 v2 = 0;
    n = 0;
    while (!rv2 && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_lat", 32'(n), 2);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(rv2), 1);
      chk("bp_rdata", rd2, 32'h112233AA);
      chk("bp_ready", 32'(rdy2), 0);
    end
    @(negedge clk);
    rresp = 1;
    @(posedge clk);
    #1;
    chk("bp_release_ready", 32'(rdy2), 1);
    chk("bp_release_valid", 32'(rv2), 0);

    // zero-latency instance
    txn(1, 1, 16, 32'h12345678, 4'hF, rd, er, lat, t);
    chk("l0_store_lat", 32'(lat), 0);
    chk("l0_store_rdata", rd, 0);
    tprev = t;
    txn(1, 0, 16, 0, 4'h0, rd, er, lat, t);
    chk("l0_load_lat", 32'(lat), 0);
    chk("l0_load_rdata", rd, 32'h12345678);
    chk("l0_gap", 32'(t - tprev), 20);
    tprev = t;
    txn(1, 0, 17, 0, 4'h0, rd, er, lat, t);
    chk("l0_mis_err", 32'(er), 1);
    chk("l0_mis_rdata", rd, 0);
    chk("l0_gap2", 32'(t - tprev), 20);

    // randomized traffic against a byte-array model
    for (int k = 0; k < 64; k++) begin
      wd = $urandom;
      for (int b = 0; b < 4; b++) mb[4*k + b] = wd[8*b +: 8];
      txn(0, 1, 32'(4*k), wd, 4'hF, rd, er, lat, t);
      chk("fill_err", 32'(er), 0);
    end
    for (int k = 0; k < 300; k++) begin
      w  = 1'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd = $urandom;
      be = 4'($urandom);
      exp_er = (a[1:0] != 2'b00) || (a >= 256);
      exp_rd = 0;
      if (!exp_er && !w) exp_rd = {mb[a + 3], mb[a + 2], mb[a + 1], mb[a]};
      if (!exp_er && w)
        for (int b = 0; b < 4; b++) if (be[b]) mb[a + b] = wd[8*b +: 8];
      txn(0, w, a, wd, be, rd, er, lat, t);
      chk("rnd_rdata", rd, exp_rd);
      chk("rnd_err", 32'(er), 32'(exp_er));
      chk("rnd_lat", 32'(lat), 2);
      if (k > 0) chk("rnd_gap", 32'(t - tprev), 40);
      tprev = t;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
